// File: rtl/gate_array_pipe.sv
// Registered bitwise gate array with valid/ready handshake and an XOR-fold
// accumulate mode that collapses a multi-beat packet into one result word.

module gate_lane (
    input  logic [2:0] op,
    input  logic       a,
    input  logic       b,
    output logic       r
);
    always_comb begin
        r = 1'b0;
        case (op)
            3'd0: r = a & b;
            3'd1: r = a | b;
            3'd2: r = ~(a & b);
            3'd3: r = ~(a | b);
            3'd4: r = a ^ b;
            3'd5: r = ~(a ^ b);
            3'd6: r = ~a;
            3'd7: r = a;
            default: r = 1'b0;
        endcase
    end
endmodule

module gate_array_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic             acc_en,
    input  logic             in_last,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic [CNT_W-1:0] beats
);
    typedef enum logic {IDLE, ACCUM} state_t;

    state_t           state;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             accept;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        gate_lane u_lane (.op(op), .a(a[i]), .b(b[i]), .r(r[i]));
    end

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    // Beat count saturates rather than wrapping so long packets stay recognisable.
    assign cnt_inc  = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            y         <= '0;
            beats     <= '0;
        end else begin
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            if (accept) begin
                case (state)
                    IDLE: begin
                        if (acc_en && !in_last) begin
                            acc   <= r;
                            cnt   <= CNT_W'(1);
                            state <= ACCUM;
                        end else begin
                            y         <= r;
                            beats     <= CNT_W'(1);
                            out_valid <= 1'b1;
                        end
                    end
                    ACCUM: begin
                        if (in_last) begin
                            y         <= acc ^ r;
                            beats     <= cnt_inc;
                            out_valid <= 1'b1;
                            acc       <= '0;
                            cnt       <= '0;
                            state     <= IDLE;
                        end else begin
                            acc <= acc ^ r;
                            cnt <= cnt_inc;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_gate_array_pipe.sv
// Directed + randomized bench for gate_array_pipe; two instances (CNT_W=8 and
// CNT_W=2) share stimulus and are checked against a packet-level model.

module tb_gate_array_pipe;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0, acc_en = 1'b0, in_last = 1'b0, out_ready = 1'b0;
    logic [2:0] op = '0;
    logic [7:0] a = '0, b = '0;
    logic       ir8, ov8, ir2, ov2;
    logic [7:0] y8, y2, b8;
    logic [1:0] b2;

    int n_pass = 0, n_tot = 0;
    int drains = 0;

    // model: output register contents and any open packet
    bit         m_valid;
    logic [7:0] m_y;
    int         m_beats;
    bit         m_open;
    logic [7:0] m_x;
    int         m_len;

    always #5 clk = ~clk;

    gate_array_pipe #(.WIDTH(8), .CNT_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir8), .op(op),
        .acc_en(acc_en), .in_last(in_last), .a(a), .b(b), .out_valid(ov8),
        .out_ready(out_ready), .y(y8), .beats(b8));

    gate_array_pipe #(.WIDTH(8), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir2), .op(op),
        .acc_en(acc_en), .in_last(in_last), .a(a), .b(b), .out_valid(ov2),
        .out_ready(out_ready), .y(y2), .beats(b2));

    function automatic logic [7:0] gate(logic [2:0] o, logic [7:0] x, logic [7:0] z);
        case (o)
            3'd0: return x & z;
            3'd1: return x | z;
            3'd2: return ~(x & z);
            3'd3: return ~(x | z);
            3'd4: return x ^ z;
            3'd5: return ~(x ^ z);
            3'd6: return ~x;
            default: return x;
        endcase
    endfunction

    function automatic int sat(int n, int maxv);
        return (n > maxv) ? maxv : n;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_valid = 0; m_y = '0; m_beats = 0; m_open = 0; m_x = '0; m_len = 0;
    endtask

    task automatic chk_out(string tag);
        chk({tag, ".out_valid8"}, 32'(ov8), 32'(m_valid));
        chk({tag, ".y8"}, 32'(y8), 32'(m_y));
        chk({tag, ".beats8"}, 32'(b8), 32'(sat(m_beats, 255)));
        chk({tag, ".out_valid2"}, 32'(ov2), 32'(m_valid));
        chk({tag, ".y2"}, 32'(y2), 32'(m_y));
        chk({tag, ".beats2"}, 32'(b2), 32'(sat(m_beats, 3)));
    endtask

    task automatic step(string tag, bit v, logic [2:0] o, logic [7:0] ai, logic [7:0] bi,
                        bit ae, bit il, bit ordy);
        bit         rdy;
        logic [7:0] r;
        @(negedge clk);
        in_valid = v; op = o; a = ai; b = bi; acc_en = ae; in_last = il; out_ready = ordy;
        #1;
        rdy = !m_valid || ordy;
        chk({tag, ".in_ready8"}, 32'(ir8), 32'(rdy));
        chk({tag, ".in_ready2"}, 32'(ir2), 32'(rdy));
        if (ov8 && ordy) drains++;
        @(posedge clk);
        if (m_valid && ordy) m_valid = 0;
        if (v && rdy) begin
            r = gate(o, ai, bi);
            if (!m_open) begin
                if (ae && !il) begin
                    m_open = 1; m_x = r; m_len = 1;
                end else begin
                    m_valid = 1; m_y = r; m_beats = 1;
                end
            end else begin
                m_x = m_x ^ r;
                m_len++;
                if (il) begin
                    m_open = 0; m_valid = 1; m_y = m_x; m_beats = m_len;
                end
            end
        end
        #1;
        chk_out(tag);
    endtask

    task automatic do_reset(int cycles);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        for (int i = 0; i < cycles; i++) begin
            in_valid = 1'($urandom); op = 3'($urandom); a = 8'($urandom); b = 8'($urandom);
            acc_en = 1'($urandom); in_last = 1'($urandom); out_ready = 1'($urandom);
            #1;
            chk_out("reset");
            chk("reset.in_ready8", 32'(ir8), 32'd1);
            @(negedge clk);
        end
        rst_n = 1'b1;
        in_valid = 1'b0;
        // first edge out of reset carries no beat
        step("post_reset", 0, 3'd0, 8'h00, 8'h00, 0, 0, 1);
    endtask

    logic [7:0] sweep_exp [8];

    initial begin
        sweep_exp = '{8'h30, 8'hFC, 8'hCF, 8'h03, 8'hCC, 8'h33, 8'h0F, 8'hF0};
        model_reset();
        do_reset(3);

        for (int i = 0; i < 8; i++) begin
            step("sweep", 1, 3'(i), 8'hF0, 8'h3C, 0, $urandom_range(0, 1), 1);
            chk("sweep.const_y", 32'(y8), 32'(sweep_exp[i]));
            chk("sweep.const_beats", 32'(b8), 32'd1);
        end
        step("drain", 0, 3'd0, 8'h00, 8'h00, 0, 0, 1);

        step("acc1", 1, 3'd0, 8'hFF, 8'h0F, 1, 0, 1);
        step("acc2", 1, 3'd0, 8'hF0, 8'hFF, 0, 0, 1);
        chk("acc.no_output", 32'(ov8), 32'd0);
        step("acc3", 1, 3'd0, 8'hAA, 8'hFF, 1, 1, 1);
        chk("acc.const_y", 32'(y8), 32'h55);
        chk("acc.const_beats", 32'(b8), 32'd3);
        step("drain", 0, 3'd0, 8'h00, 8'h00, 0, 0, 1);

        drains = 0;
        step("bp_nor", 1, 3'd3, 8'hF0, 8'h3C, 0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            step("bp_hold", 1, 3'd1, 8'h01, 8'h02, 0, 0, 0);
            chk("bp.in_ready_low", 32'(ir8), 32'd0);
            chk("bp.held_y", 32'(y8), 32'h03);
        end
        step("bp_release", 1, 3'd1, 8'h01, 8'h02, 0, 0, 1);
        chk("bp.handover_valid", 32'(ov8), 32'd1);
        step("drain", 0, 3'd0, 8'h00, 8'h00, 0, 0, 1);
        chk("bp.output_count", 32'(drains), 32'd2);

        step("mid1", 1, 3'd4, 8'h5A, 8'h0F, 1, 0, 1);
        step("mid2", 1, 3'd1, 8'h80, 8'h00, 1, 0, 1);
        do_reset(1);
        step("mid_after", 1, 3'd1, 8'h01, 8'h02, 0, 0, 1);
        chk("mid.const_y", 32'(y8), 32'h03);
        chk("mid.const_beats", 32'(b8), 32'd1);
        step("drain", 0, 3'd0, 8'h00, 8'h00, 0, 0, 1);

        for (int i = 0; i < 5; i++)
            step("sat", 1, 3'd4, 8'h01, 8'h00, 1, (i == 4), 1);
        chk("sat.const_y2", 32'(y2), 32'h01);
        chk("sat.const_beats2", 32'(b2), 32'd3);
        chk("sat.const_beats8", 32'(b8), 32'd5);
        step("drain", 0, 3'd0, 8'h00, 8'h00, 0, 0, 1);

        for (int i = 0; i < 400; i++)
            step("rand", ($urandom_range(0, 3) != 0), 3'($urandom), 8'($urandom), 8'($urandom),
                 1'($urandom), ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) != 0));
        step("drain", 0, 3'd0, 8'h00, 8'h00, 0, 0, 1);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule

// File: doc/gate_array_pipe.md
# gate_array_pipe

Parametrised, registered successor to the two-output NAND/NOR gate. It applies one of eight selectable bitwise gate functions across `WIDTH`-bit operands. It also supports an accumulate mode that XOR-folds gate results over a multi-beat packet into a single output word. It sits between a valid/ready producer and consumer in the datapath and provides one output register with back-pressure.

## Interface
Parameters:
- `WIDTH`, default 8: operand and result width in bits (≥1).
- `CNT_W`, default 8: width of the beat counter (≥2).

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  input beat present.
- `in_ready`  out  1  block can accept a beat this cycle.
- `op`  in  3  gate select, sampled with the beat:
  - 000 AND, 001 OR, 010 NAND, 011 NOR
  - 100 XOR, 101 XNOR, 110 NOT a, 111 BUF a
- `acc_en`  in  1  beat starts or continues an accumulated packet.
- `in_last`  in  1  final beat of an accumulated packet.
- `a`  in  WIDTH  operand A.
- `b`  in  WIDTH  operand B (ignored for NOT/BUF).
- `out_valid`  out  1  result word held in the output register.
- `out_ready`  in  1  consumer accepts the result.
- `y`  out  WIDTH  result word.
- `beats`  out  CNT_W  number of input beats folded into `y`; saturates at 2^CNT_W−1.

## Operation
- Beat accepted when `in_valid && in_ready`. Per-beat result `r = op(a, b)`, evaluated bitwise on all WIDTH bits.
- State machine, two states:
  - **IDLE** (no partial packet):
    - Accepted beat with `acc_en=0`, or with `acc_en=1 && in_last=1`: load `y=r`, `beats=1`, set `out_valid`. Stay IDLE.
    - Accepted beat with `acc_en=1 && in_last=0`: `acc=r`, `cnt=1`. Go to ACCUM. No output.
  - **ACCUM** (partial packet held):
    - `acc_en` is ignored; every accepted beat belongs to the packet. `op` may change per beat.
    - Beat with `in_last=0`: `acc=acc^r`, `cnt=cnt+1` (saturating). Stay ACCUM.
    - Beat with `in_last=1`: `y=acc^r`, `beats=cnt+1` (saturating), set `out_valid`. Go to IDLE.
- `in_last` is ignored in IDLE when `acc_en=0`.
- `out_valid` clears on `out_valid && out_ready` unless a new output-producing beat is accepted in the same cycle; in that case the register reloads and `out_valid` stays 1.
- `y` and `beats` hold stable while `out_valid=1 && out_ready=0`.
- Reset (asynchronous, any time, including mid-packet):
  - state=IDLE, `acc=0`, `cnt=0`, `out_valid=0`, `y=0`, `beats=0`.
  - The partial packet is discarded.
  - `in_ready` is 1 while out of reset with an empty output register.

## Timing
- `in_ready = !out_valid || out_ready`, combinational from `out_ready`; no other combinational input-to-output path.
- `in_ready` applies to all beats, including non-output ACCUM beats.
- Latency: an output-producing beat accepted at edge N gives `out_valid=1` and valid `y`/`beats` after edge N.
- Throughput: one beat per cycle when `out_ready=1` continuously.
- Back-to-back single-beat ops with `out_ready` held 1 produce one result per cycle with no bubbles.
- ACCUM beats produce no output cycles. A k-beat packet yields exactly one output, one cycle after its last beat.
- Simultaneous output drain and new output-producing accept: new data is visible after the edge and no cycle has `out_valid=0`.
- Reset deassertion takes effect on the first rising edge with `rst_n=1`. The bench must not drive beats in that cycle.

## Test plan
- Reset: hold `rst_n=0` for 3 cycles with random inputs → `out_valid=0`, `y=0x00`, `beats=0`, `in_ready=1`.
- Single-beat op sweep, WIDTH=8, `a=0xF0`, `b=0x3C`, `acc_en=0`, ops 0–7 → `y`:
  - 0x30, 0xFC, 0xCF, 0x03
  - 0xCC, 0x33, 0x0F, 0xF0
  - each with `beats=1`, one cycle after accept.
- Accumulate, three beats:
  - beats: (AND, 0xFF, 0x0F); (AND, 0xF0, 0xFF); (AND, 0xAA, 0xFF, `in_last=1`)
  - → exactly one output, `y=0x55`, `beats=3`, one cycle after the third beat.
- Back-pressure: `out_ready=0` after a NOR of 0xF0/0x3C → `y=0x03` held and `in_ready=0` for 5 cycles. Raising `out_ready` with a queued OR 0x01/0x02 beat → `out_valid` stays 1 and `y=0x03` is replaced by 0x03 with the new beat's `beats=1`. The bench confirms the handover with a scoreboard count of 2 outputs.
- Reset mid-packet: two accumulate beats, then a `rst_n` pulse, then a single-beat OR 0x01/0x02 → `y=0x03`, `beats=1`; no stale accumulation.
- Counter saturation, CNT_W=2:
  - 5-beat packet of XOR 0x01/0x00 → `y=0x01`, `beats=3`.
